// File: rtl/imem_loader.sv
// imem_loader: byte-stream to instruction-memory word loader.
// Packs a valid/ready byte stream little-endian into 32-bit words, writes them at
// consecutive word addresses from 0, holds the CPU while loading and pulses a CPU
// reset once the program is in place.
module imem_loader #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_reset,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFlush,
    StDone
  } state_e;

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         word_buf_q, word_buf_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;

  logic                accept;
  logic                word_end;
  logic                finish;
  logic [31:0]         word_cur;

  // Byte handshake: the loader takes one byte per cycle for the whole LOAD state.
  assign in_ready = (state_q == StLoad);
  assign accept   = in_ready & in_valid;
  assign word_end = (lane_q == 2'd3) | in_last;

  // Current word with the incoming byte merged into its lane; upper lanes stay zero
  // because the buffer is cleared at every word boundary.
  always_comb begin
    word_cur = word_buf_q;
    word_cur[{lane_q, 3'b000} +: 8] = in_byte;
  end

  // Next-state and datapath updates; strobes default low every cycle.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    word_buf_d   = word_buf_q;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    cpu_reset_d  = 1'b0;
    done_d       = done_q;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;
    finish       = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (load_start) begin
          state_d      = StLoad;
          lane_d       = 2'd0;
          word_buf_d   = 32'h0;
          word_count_d = '0;
          done_d       = 1'b0;
          overflow_d   = 1'b0;
          cpu_hold_d   = 1'b1;
        end
      end

      StLoad: begin
        if (accept) begin
          if (!word_end) begin
            word_buf_d = word_cur;
            lane_d     = lane_q + 2'd1;
          end else begin
            word_buf_d = 32'h0;
            lane_d     = 2'd0;
            if (word_count_q == DepthCnt) begin
              // Memory already full: drop the word and end the load.
              overflow_d = 1'b1;
              finish     = 1'b1;
            end else begin
              mem_we_d     = 1'b1;
              mem_waddr_d  = word_count_q[ADDR_W-1:0];
              mem_wdata_d  = word_cur;
              word_count_d = word_count_q + CntOne;
              if (!in_last) begin
                state_d = StLoad;
              end else if (lane_q == 2'd3) begin
                finish = 1'b1;
              end else begin
                // Partial last word: its write is issued during FLUSH.
                state_d = StFlush;
              end
            end
          end
        end
      end

      StFlush: begin
        finish = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Common entry into DONE: release the CPU and pulse its reset.
    if (finish) begin
      state_d     = StDone;
      cpu_hold_d  = 1'b0;
      cpu_reset_d = 1'b1;
      done_d      = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      lane_q       <= 2'd0;
      word_buf_q   <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= 32'h0;
      cpu_hold_q   <= 1'b0;
      cpu_reset_q  <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      word_buf_q   <= word_buf_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  // A write registered just before Reset rises must not reach memory in the reset cycle.
  assign mem_we     = mem_we_q & ~Reset;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule
